// File: rtl/memoria_instrucoes.sv
// Instruction memory with a combinational fetch port and a framed byte-serial
// program loader that holds the processor while memory is being rewritten.
module memoria_instrucoes #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] I_addr,
  input  logic        I_rd,
  output logic [15:0] I_data,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        ld_done,
  output logic        ld_err,
  output logic        cpu_hold
);

  localparam int          DEPTH        = 1 << ADDR_W;
  localparam logic [15:0] INVALID_WORD = 16'hF000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Running XOR checksum over frame bytes.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Word count byte, truncated to the address width; zero means full depth.
  function automatic logic [ADDR_W:0] word_count(input logic [7:0] b);
    logic [ADDR_W-1:0] n;
    n = b[ADDR_W-1:0];
    if (n == '0) word_count = {1'b1, {ADDR_W{1'b0}}};
    else         word_count = {1'b0, n};
  endfunction

  logic [15:0]     mem_r [DEPTH];
  state_t          state_r, state_s;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W:0]   words_left_r;
  logic [7:0]      hi_byte_r;
  logic [7:0]      chk_r;
  logic            ld_ready_r, ld_done_r, ld_err_r, cpu_hold_r;
  logic            accept_s;
  logic            chk_ok_s;

  assign accept_s = ld_valid && ld_ready_r;
  assign chk_ok_s = (ld_byte == chk_r);

  // Next-state decode of the loader FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (ld_start) state_s = S_COUNT;
        else          state_s = S_IDLE;
      end
      S_COUNT: begin
        if (accept_s) state_s = S_HIGH;
        else          state_s = S_COUNT;
      end
      S_HIGH: begin
        if (accept_s) state_s = S_LOW;
        else          state_s = S_HIGH;
      end
      S_LOW: begin
        if (accept_s && (words_left_r == (ADDR_W+1)'(1))) state_s = S_CHECK;
        else if (accept_s)                                state_s = S_HIGH;
        else                                              state_s = S_LOW;
      end
      S_CHECK: begin
        if (accept_s && chk_ok_s) state_s = S_DONE;
        else if (accept_s)        state_s = S_IDLE;
        else                      state_s = S_CHECK;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      wr_addr_r    <= '0;
      words_left_r <= '0;
      hi_byte_r    <= 8'h00;
      chk_r        <= 8'h00;
      ld_ready_r   <= 1'b0;
      ld_done_r    <= 1'b0;
      ld_err_r     <= 1'b0;
      cpu_hold_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      ld_ready_r <= (state_s inside {S_COUNT, S_HIGH, S_LOW, S_CHECK});
      ld_done_r  <= (state_s == S_DONE);
      cpu_hold_r <= (state_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (ld_start) begin
            wr_addr_r <= '0;
            chk_r     <= 8'h00;
            ld_err_r  <= 1'b0;
          end
        end
        S_COUNT: begin
          if (accept_s) begin
            words_left_r <= word_count(ld_byte);
            chk_r        <= chk_fold(chk_r, ld_byte);
          end
        end
        S_HIGH: begin
          if (accept_s) begin
            hi_byte_r <= ld_byte;
            chk_r     <= chk_fold(chk_r, ld_byte);
          end
        end
        S_LOW: begin
          if (accept_s) begin
            wr_addr_r    <= wr_addr_r + ADDR_W'(1);
            words_left_r <= words_left_r - (ADDR_W+1)'(1);
            chk_r        <= chk_fold(chk_r, ld_byte);
          end
        end
        S_CHECK: begin
          if (accept_s && !chk_ok_s) ld_err_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Program memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && (state_r == S_LOW) && accept_s) mem_r[wr_addr_r] <= {hi_byte_r, ld_byte};
  end

  // Fetch port: only in-range reads while idle see memory, all else is an invalid opcode.
  always_comb begin
    I_data = INVALID_WORD;
    if (I_rd && (I_addr[15:ADDR_W] == '0) && (state_r == S_IDLE)) I_data = mem_r[I_addr[ADDR_W-1:0]];
    else                                                          I_data = INVALID_WORD;
  end

  assign ld_ready = ld_ready_r;
  assign ld_done  = ld_done_r;
  assign ld_err   = ld_err_r;
  assign cpu_hold = cpu_hold_r;

endmodule

// File: tb/tb_memoria_instrucoes.sv
// Randomized bench for memoria_instrucoes: a byte-counting frame model predicts
// status outputs and memory contents, checked every cycle, plus literal checks.
module tb_memoria_instrucoes;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] I_addr;
  logic        I_rd;
  logic [15:0] I_data;
  logic        ld_start, ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready, ld_done, ld_err, cpu_hold;

  memoria_instrucoes #(.ADDR_W(8), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .I_addr(I_addr), .I_rd(I_rd), .I_data(I_data),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_done   = 0;
  bit     chk_en   = 1'b0;
  bit     fetch_manual = 1'b0;
  longint cyc = 0;

  // Reference model: memory image plus a count of bytes accepted in the session.
  logic [15:0] m_mem [256];
  bit          m_valid [256];
  bit          m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int          m_got = 0, m_n = 0, m_idx;
  logic [7:0]  m_xor = 8'h00, m_hi = 8'h00;
  logic [7:0]  fq [$];
  logic [15:0] exp_d;
  bit          known;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset !== 1'b1) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_got = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_busy) begin
      if (ld_start) begin m_busy = 1'b1; m_got = 0; m_xor = 8'h00; m_err = 1'b0; end
    end else if (ld_valid) begin
      if (m_got == 0) begin
        m_n = (ld_byte == 8'h00) ? 256 : int'(ld_byte);
      end else if (m_got <= 2 * m_n) begin
        if (m_got % 2 == 1) m_hi = ld_byte;
        else begin
          m_idx = ((m_got - 2) / 2) % 256;
          m_mem[m_idx] = {m_hi, ld_byte};
          m_valid[m_idx] = 1'b1;
        end
      end else begin
        if (ld_byte == m_xor) m_done = 1'b1;
        else m_err = 1'b1;
        m_busy = 1'b0;
      end
      m_xor = m_xor ^ ld_byte;
      m_got++;
    end
  end

  // Per-cycle comparison, mid low phase when inputs and outputs are settled.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check_b("ld_ready", ld_ready, m_busy);
      check_b("cpu_hold", cpu_hold, m_busy || m_done);
      check_b("ld_done",  ld_done,  m_done);
      check_b("ld_err",   ld_err,   m_err);
      if (ld_done === 1'b1) n_done++;
      known = 1'b1;
      exp_d = 16'hF000;
      if (I_rd === 1'b1 && I_addr[15:8] == 8'h00 && !m_busy && !m_done) begin
        exp_d = m_mem[I_addr[7:0]];
        known = m_valid[I_addr[7:0]];
      end
      if (known) check("I_data", I_data, exp_d);
    end
  end

  task automatic step();
    @(negedge clk);
    if (!fetch_manual) begin
      I_rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) I_addr = 16'($urandom);
      else I_addr = {8'h00, 8'($urandom)};
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    ld_valid = 1'b1;
    ld_byte  = b;
    while (ld_ready !== 1'b1 && g < 20) begin step(); g++; end
    if (g >= 20) begin
      n_checks++;
      $display("FAIL ld_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    step();
  endtask

  task automatic start_session();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic send_bytes(input int stall_max, input bit poke_mid);
    for (int i = 0; i < fq.size(); i++) begin
      if (stall_max > 0) begin
        int s;
        s = $urandom_range(0, stall_max);
        ld_valid = 1'b0;
        repeat (s) step();
      end
      if (poke_mid && i == 3) ld_start = 1'b1;
      send_byte(fq[i]);
      ld_start = 1'b0;
    end
    ld_valid = 1'b0;
  endtask

  task automatic build_frame(input int n, input bit bad);
    logic [7:0] x, b;
    fq.delete();
    b = 8'(n);
    fq.push_back(b);
    x = b;
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      fq.push_back(b);
      x = x ^ b;
    end
    if (bad) x = x + 8'd1;
    fq.push_back(x);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    int d0;
    logic [15:0] w1, w2;
    reset = 1'b0; I_rd = 1'b0; I_addr = 16'h0000;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00;
    for (int i = 0; i < 256; i++) begin m_valid[i] = 1'b0; m_mem[i] = 16'h0000; end
    step();
    chk_en = 1'b1;
    step();

    // Reset state and out-of-range fetch.
    fetch_manual = 1'b1;
    I_rd = 1'b1; I_addr = 16'h0100;
    #1;
    check_b("rst_ld_ready", ld_ready, 1'b0);
    check_b("rst_ld_done",  ld_done,  1'b0);
    check_b("rst_ld_err",   ld_err,   1'b0);
    check_b("rst_cpu_hold", cpu_hold, 1'b0);
    check("fetch_oor", I_data, 16'hF000);
    I_rd = 1'b0; I_addr = 16'h0005;
    #1;
    check("fetch_no_rd", I_data, 16'hF000);
    reset = 1'b1;
    fetch_manual = 1'b0;
    step();

    // Good three-word load with latency check.
    fq = '{8'h03, 8'h30, 8'h05, 8'h31, 8'h07, 8'h20, 8'h01, 8'h21};
    d0 = n_done;
    t0 = cyc;
    start_session();
    send_bytes(0, 1'b0);
    #1;
    check("done_latency", 16'(cyc - t0), 16'd9);
    check_b("good_ld_done", ld_done, 1'b1);
    step(); step();
    #2;
    check("good_done_count", 16'(n_done - d0), 16'd1);
    fetch_manual = 1'b1; I_rd = 1'b1;
    I_addr = 16'h0000; #1; check("good_w0", I_data, 16'h3005);
    I_addr = 16'h0001; #1; check("good_w1", I_data, 16'h3107);
    I_addr = 16'h0002; #1; check("good_w2", I_data, 16'h2001);
    check_b("good_ld_err", ld_err, 1'b0);
    fetch_manual = 1'b0;
    step();

    // Bad checksum: words still land, error latched, no done pulse.
    fq = '{8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h04};
    d0 = n_done;
    start_session();
    send_bytes(0, 1'b0);
    #1;
    check_b("bad_ld_err", ld_err, 1'b1);
    check_b("bad_no_done", ld_done, 1'b0);
    step(); step();
    #2;
    check("bad_done_count", 16'(n_done - d0), 16'd0);
    fetch_manual = 1'b1; I_rd = 1'b1;
    I_addr = 16'h0000; #1; check("bad_w0", I_data, 16'h1111);
    I_addr = 16'h0002; #1; check("bad_w2", I_data, 16'h3333);
    fetch_manual = 1'b0;
    step();

    // Stalled good frame, start pulsed mid-load and in DONE; error clears on start.
    fq = '{8'h03, 8'h30, 8'h05, 8'h31, 8'h07, 8'h20, 8'h01, 8'h21};
    start_session();
    #1;
    check_b("err_cleared", ld_err, 1'b0);
    send_bytes(2, 1'b1);
    ld_start = 1'b1;
    #1;
    check_b("stall_ld_done", ld_done, 1'b1);
    step();
    ld_start = 1'b0;
    #1;
    check_b("start_in_done_ignored", cpu_hold, 1'b0);
    fetch_manual = 1'b1; I_rd = 1'b1;
    I_addr = 16'h0000; #1; check("stall_w0", I_data, 16'h3005);
    I_addr = 16'h0001; #1; check("stall_w1", I_data, 16'h3107);
    I_addr = 16'h0002; #1; check("stall_w2", I_data, 16'h2001);
    fetch_manual = 1'b0;
    step();

    // Random short frames, good and bad.
    for (int k = 0; k < 6; k++) begin
      build_frame($urandom_range(1, 6), 1'($urandom_range(0, 1)));
      start_session();
      send_bytes(1, 1'b0);
      step(); step();
    end

    // Full-depth load (N=0 encodes 256 words), then sweep every address.
    build_frame(256, 1'b0);
    w1 = {fq[3], fq[4]};
    w2 = {fq[5], fq[6]};
    start_session();
    send_bytes(1, 1'b0);
    #1;
    check_b("full_ld_done", ld_done, 1'b1);
    step();
    fetch_manual = 1'b1; I_rd = 1'b1;
    I_addr = 16'h0000; #1; check("full_w0", I_data, {fq[1], fq[2]});
    I_addr = 16'h00FF; #1; check("full_w255", I_data, {fq[511], fq[512]});
    for (int i = 0; i < 256; i++) begin
      I_addr = 16'(i);
      step();
    end

    // Fetch blocked while loading, then reset in the middle of a word.
    fq = '{8'h04, 8'hA1, 8'hA2, 8'hB1};
    start_session();
    send_byte(fq[0]);
    I_addr = 16'h0000;
    #1;
    check("fetch_in_high", I_data, 16'hF000);
    send_byte(fq[1]);
    send_byte(fq[2]);
    send_byte(fq[3]);
    ld_valid = 1'b0;
    reset = 1'b0;
    step();
    #1;
    check_b("midrst_cpu_hold", cpu_hold, 1'b0);
    check_b("midrst_ld_ready", ld_ready, 1'b0);
    reset = 1'b1;
    I_addr = 16'h0000; #1; check("midrst_w0", I_data, 16'hA1A2);
    I_addr = 16'h0001; #1; check("midrst_w1", I_data, w1);
    I_addr = 16'h0002; #1; check("midrst_w2", I_data, w2);
    fetch_manual = 1'b0;
    step(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
